// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, port ids and counter width for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        CLR    = 3'd4
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and Memory bus bundle for mem_arbiter
// slave modport: arbiter side (takes requests, drives Memory strobes)
// master modport: requesters plus Memory model side
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              clr_req;
    logic              clr_done;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_to_write;
    logic              mem_writeif;
    logic              mem_readif;
    logic              mem_clear;
    logic [DATA_W-1:0] mem_output_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, mem_output_data,
        output done0, done1, rdata, clr_done,
               mem_address, mem_data_to_write, mem_writeif, mem_readif, mem_clear
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, mem_output_data,
        input  done0, done1, rdata, clr_done,
               mem_address, mem_data_to_write, mem_writeif, mem_readif, mem_clear
    );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select for the two requesters
// Inputs: req0, req1, last_served (only with MEM_ARB_ROUND_ROBIN_EN)
// Outputs: grant_id (PORT_I/PORT_D), grant_valid
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port not served last; otherwise port 1 wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_served,
`endif
    output logic grant_id,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = req1 ? PORT_D : PORT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            grant_id = ~last_served;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer for the single-port Memory block
// Ports: clk, reset (sync, active-high), bus (mem_arbiter_if.slave: requests, done/rdata,
//        clear handshake, Memory address/data/strobes/output_data)
// Optional: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);

    state_t            state;
    logic              lat_we;
    logic              lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  rd_cnt;
    logic              done0_q;
    logic              done1_q;
    logic              clr_done_q;
    logic              writeif_q;
    logic              readif_q;
    logic              clear_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_id;
    logic              grant_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_served;
`endif

    mem_arb_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_served (last_served),
`endif
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_port   <= PORT_I;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rd_cnt     <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            clr_done_q <= 1'b0;
            writeif_q  <= 1'b0;
            readif_q   <= 1'b0;
            clear_q    <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_served <= PORT_D;
`endif
        end else begin
            // every strobe and pulse is single-cycle; re-asserted only on entry to its state
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            clr_done_q <= 1'b0;
            writeif_q  <= 1'b0;
            readif_q   <= 1'b0;
            clear_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state      <= CLR;
                        clear_q    <= 1'b1;
                        clr_done_q <= 1'b1;
                    end else if (grant_valid) begin
                        state     <= ACCESS;
                        lat_port  <= grant_id;
                        lat_we    <= (grant_id == PORT_D) ? bus.we1    : bus.we0;
                        lat_addr  <= (grant_id == PORT_D) ? bus.addr1  : bus.addr0;
                        lat_wdata <= (grant_id == PORT_D) ? bus.wdata1 : bus.wdata0;
                        if ((grant_id == PORT_D) ? bus.we1 : bus.we0) begin
                            writeif_q <= 1'b1;
                        end else begin
                            readif_q <= 1'b1;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_served <= grant_id;
`endif
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        state   <= DONE;
                        done0_q <= (lat_port == PORT_I);
                        done1_q <= (lat_port == PORT_D);
                    end else begin
                        state  <= WAIT;
                        rd_cnt <= RD_LOAD;
                    end
                end
                WAIT: begin
                    if (rd_cnt == '0) begin
                        state   <= DONE;
                        rdata_q <= bus.mem_output_data;
                        done0_q <= (lat_port == PORT_I);
                        done1_q <= (lat_port == PORT_D);
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                CLR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // the latch itself feeds Memory, so address/data stay stable around the strobe
    assign bus.mem_address       = lat_addr;
    assign bus.mem_data_to_write = lat_wdata;
    assign bus.mem_writeif       = writeif_q;
    assign bus.mem_readif        = readif_q;
    assign bus.mem_clear         = clear_q;
    assign bus.done0             = done0_q;
    assign bus.done1             = done1_q;
    assign bus.clr_done          = clr_done_q;
    assign bus.rdata             = rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 16-bit Memory block.
- Shares Memory between an instruction-fetch port (port 0) and a data load/store port (port 1).
- Serialises requests, drives Memory's address, data_to_write, writeif, readif and clear strobes, and returns read data with a one-cycle done pulse.
- Also sequences a whole-memory clear request.

Parameters:
- ADDR_W, 16, address width of requesters and Memory.
- DATA_W, 16, data width.
- RD_LAT, 1, cycles from readif strobe to valid output_data; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  port request; held high until matching done.
- we0 / we1  in  1  1 = write, 0 = read; sampled at grant.
- addr0 / addr1  in  ADDR_W  request address.
- wdata0 / wdata1  in  DATA_W  write data.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid when done0 or done1 is high for a read.
- clr_req  in  1  request full memory clear; held until clr_done.
- clr_done  out  1  one-cycle clear completion pulse.
- mem_address  out  ADDR_W  to Memory address.
- mem_data_to_write  out  DATA_W  to Memory data_to_write.
- mem_writeif / mem_readif / mem_clear  out  1  Memory strobes.
- mem_output_data  in  DATA_W  from Memory output_data.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; latched request fields 0; rd counter 0.
- Reset mid-operation abandons the transaction silently: no done pulse, strobes drop at the next edge.
- FSM states: IDLE, ACCESS, WAIT, DONE, CLR.
- IDLE selection order:
  - clr_req has highest priority -> CLR.
  - Otherwise, if any reqN is set, pick the winner, latch we/addr/wdata and the port id, then go to ACCESS.
- ACCESS (exactly 1 cycle): mem_address/mem_data_to_write come from the latch.
  - Write: mem_writeif=1, next state DONE.
  - Read: mem_readif=1, counter loaded with RD_LAT-1, next state WAIT.
- WAIT: counter decrements each cycle. When it reaches 0, capture mem_output_data into rdata and go to DONE. With RD_LAT=1, WAIT lasts one cycle.
- DONE (1 cycle): done of the served port =1, rdata held, next state IDLE.
- CLR: mem_clear=1 and clr_done=1 for one cycle, then IDLE.
- Strobes are mutually exclusive and high only in ACCESS/CLR.
- Latency: write req -> done is 3 cycles (IDLE, ACCESS, DONE). Read req -> done is 3+RD_LAT cycles.
- Requester rules:
  - Must drop req on the edge after done. A req still high when IDLE is re-entered is a new transaction.
  - Requests arriving during a busy cycle wait; nothing is dropped.
  - Inputs are ignored outside IDLE.
- Fixed priority (default): port 1 wins simultaneous req0/req1.
- rdata keeps its last read value after a write completion.
- Address wrap and width are handled by Memory; the arbiter passes the address unchanged.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a last_served flop (reset 1) tracks the last served port. On a tie the port not served last wins; the flop updates on every grant. The first tie after reset goes to port 0.
- Undefined: fixed priority, port 1 wins ties; the last_served flop is absent.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE=0, ACCESS=1, WAIT=2, DONE=3, CLR=4), 3 bits;
  - the port id constants PORT_I=0, PORT_D=1;
  - the RD_LAT counter width constant 4.
- One sub-module is natural: mem_arb_pick, a combinational winner select (reqs, last_served -> grant id, valid). It contains the macro-dependent logic.

Test Plan:
- Write then read, port 0: req0, we0=1, addr0=0x0001, wdata0=0x0003 -> mem_writeif for 1 cycle, done0 at cycle 3. Then read 0x0001 -> done0 with rdata=0x0003.
- Simultaneous read req0 addr 0x0003 / req1 addr 0x0005, macro undefined -> port 1 served first, port 0 served next. The done pulses are never concurrent.
- Same tie repeated 4 times, MEM_ARB_ROUND_ROBIN_EN defined -> grant order 0,1,0,1.
- clr_req together with req1 -> mem_clear and clr_done first, then req1 served. A later read of 0x0001 returns 0x0000.
- Reset asserted during WAIT with RD_LAT=3 -> no done pulse, all outputs 0 on the next cycle. A new req0 completes normally afterwards.
- RD_LAT=3 read of 0x0005 after writing 0x0006 -> done1 exactly 6 cycles after grant sampling, rdata=0x0006.
